// File: rtl/ccsds_turbo_enc_sink_pkg.sv
// rtl/ccsds_turbo_enc_sink_pkg.sv - shared code-rate constants and puncture helpers
// Contents: cCODE_* rate codes, word_bits_t (serialised trellis word, bit 0 leaves first),
//           get_code_nbits(code) -> bits per word, punct_word() -> word in CCSDS bit order.
package ccsds_turbo_enc_sink_pkg;

  localparam logic [1:0] cCODE_1by2 = 2'd0;
  localparam logic [1:0] cCODE_1by3 = 2'd1;
  localparam logic [1:0] cCODE_1by4 = 2'd2;
  localparam logic [1:0] cCODE_1by6 = 2'd3;

  typedef logic [5:0] word_bits_t;

  function automatic logic [2:0] get_code_nbits(input logic [1:0] code);
    case (code)
      cCODE_1by2 : return 3'd2;
      cCODE_1by3 : return 3'd3;
      cCODE_1by4 : return 3'd4;
      default    : return 3'd6;
    endcase
  endfunction

  // odd selects the rate-1/2 parity source: encoder 0 on even words, encoder 1 on odd words
  function automatic word_bits_t punct_word(input logic [1:0] code, input logic odd,
                                            input logic s, input logic [2:0] a0,
                                            input logic [2:0] a1);
    word_bits_t w;
    w = '0;
    case (code)
      cCODE_1by2 : w[1:0] = {(odd ? a1[0] : a0[0]), s};
      cCODE_1by3 : w[2:0] = {a1[0], a0[0], s};
      cCODE_1by4 : w[3:0] = {a1[0], a0[2], a0[1], s};
      default    : w      = {a1[2], a1[0], a0[2], a0[1], a0[0], s};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ccsds_turbo_enc_sink_if.sv
// rtl/ccsds_turbo_enc_sink_if.sv - codeword buffer read bus plus serial output stream
// Buffer side : ifull, orempty, oraddr, ordval, irs, ira0, ira1 (read latency 1 cycle)
// Stream side : oval, osop, oeop, odat, iready
// master = the sink block, slave = buffer plus downstream consumer.
interface ccsds_turbo_enc_sink_if #(
  parameter int pADDR_W = 8
);
  logic               ifull;
  logic               orempty;
  logic [pADDR_W-1:0] oraddr;
  logic               ordval;
  logic               irs;
  logic [2:0]         ira0;
  logic [2:0]         ira1;
  logic               oval;
  logic               osop;
  logic               oeop;
  logic               odat;
  logic               iready;

  modport master (
    input  ifull, irs, ira0, ira1, iready,
    output orempty, oraddr, ordval, oval, osop, oeop, odat
  );

  modport slave (
    output ifull, irs, ira0, ira1, iready,
    input  orempty, oraddr, ordval, oval, osop, oeop, odat
  );
endinterface

// File: rtl/ccsds_turbo_enc_sink_skid.sv
// rtl/ccsds_turbo_enc_sink_skid.sv - one-word park register for returned buffer data
// Ports: iclk, ireset (async, active-high), iclkena, wr (park din), clr (consume),
//        din/dout (punctured word), vld (word parked).
module ccsds_turbo_enc_sink_skid
  import ccsds_turbo_enc_sink_pkg::*;
(
  input  logic       iclk,
  input  logic       ireset,
  input  logic       iclkena,
  input  logic       wr,
  input  logic       clr,
  input  word_bits_t din,
  output logic       vld,
  output word_bits_t dout
);
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (iclkena) begin
      if (wr) begin
        vld  <= 1'b1;
        dout <= din;
      end else if (clr) begin
        vld  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ccsds_turbo_enc_sink.sv
// rtl/ccsds_turbo_enc_sink.sv - turbo encoder output: buffer reader and punctured bit serialiser
// Ports: iclk, ireset (async, active-high), iclkena (freeze when low),
//        icode/ilast (rate and last word index, latched at block start),
//        obusy (block in progress), bus (ccsds_turbo_enc_sink_if.master: buffer read + stream).
module ccsds_turbo_enc_sink
  import ccsds_turbo_enc_sink_pkg::*;
#(
  parameter int pADDR_W = 8
)(
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  input  logic [1:0]             icode,
  input  logic [pADDR_W-1:0]     ilast,
  output logic                   obusy,
  ccsds_turbo_enc_sink_if.master bus
);
  localparam logic [1:0] cIDLE  = 2'd0;
  localparam logic [1:0] cFETCH = 2'd1;
  localparam logic [1:0] cRUN   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         code;
  logic [pADDR_W-1:0] last;
  logic [pADDR_W-1:0] raddr;
  logic [pADDR_W-1:0] wcnt;
  logic               rd;
  logic               rdat_val;
  logic               val;
  logic               rempty;
  logic [2:0]         sym;
  logic [2:0]         nbits;
  word_bits_t         sreg;
  word_bits_t         rword;
  word_bits_t         skid_word;
  logic               skid_vld;
  logic               skid_wr;
  logic               skid_clr;
  logic               accept;
  logic               last_sym;
  logic               last_word;
  logic               word_done;
  logic               need_word;
  logic               load_skid;
  logic               load_rd;
  logic               load;

  assign nbits     = get_code_nbits(code);
  assign last_sym  = (sym == nbits - 3'd1);
  assign last_word = (wcnt == last);
  assign accept    = val & bus.iready;
  assign word_done = accept & last_sym;

  // raddr still holds the address of the word returning this cycle: the next
  // read is only issued when that word is loaded, so its parity is raddr[0].
  assign rword = punct_word(code, raddr[0], bus.irs, bus.ira0, bus.ira1);

  always_comb begin
    // a new word is wanted when the current one leaves (or none is shown) and more remain
    need_word = (state == cRUN) & !last_word & (word_done | !val);
    load_skid = need_word & skid_vld;
    load_rd   = rdat_val & ((state == cFETCH) | (need_word & !skid_vld));
    load      = load_skid | load_rd;
    skid_wr   = rdat_val & (state == cRUN) & !load_rd;
    skid_clr  = load_skid;
  end

  ccsds_turbo_enc_sink_skid u_skid (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .wr      (skid_wr),
    .clr     (skid_clr),
    .din     (rword),
    .vld     (skid_vld),
    .dout    (skid_word)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= cIDLE;
      code     <= '0;
      last     <= '0;
      raddr    <= '0;
      wcnt     <= '0;
      rd       <= 1'b0;
      rdat_val <= 1'b0;
      val      <= 1'b0;
      rempty   <= 1'b0;
      sym      <= '0;
      sreg     <= '0;
    end else if (iclkena) begin
      rdat_val <= rd;
      rd       <= 1'b0;
      rempty   <= rdat_val & (raddr == last) & (state != cIDLE);

      case (state)
        cIDLE : if (bus.ifull) begin
          state <= cFETCH;
          code  <= icode;
          last  <= ilast;
          raddr <= '0;
          rd    <= 1'b1;
        end
        cFETCH : if (rdat_val) state <= cRUN;
        cRUN   : if (word_done & last_word) state <= cIDLE;
        default: state <= cIDLE;
      endcase

      if (load) begin
        sreg <= load_skid ? skid_word : rword;
        sym  <= '0;
        val  <= 1'b1;
        wcnt <= (state == cFETCH) ? '0 : wcnt + 1'b1;
        // prefetch the following word so the boundary costs no cycle
        if (raddr != last) begin
          raddr <= raddr + 1'b1;
          rd    <= 1'b1;
        end
      end else begin
        if (word_done)               val <= 1'b0;
        if (accept & !last_sym)      sym <= sym + 3'd1;
      end
    end
  end

  assign obusy       = (state != cIDLE);
  assign bus.oraddr  = raddr;
  assign bus.ordval  = rd;
  assign bus.orempty = rempty;
  assign bus.oval    = val;
  assign bus.odat    = sreg[sym];
  assign bus.osop    = val & (wcnt == '0) & (sym == 3'd0);
  assign bus.oeop    = val & last_word & last_sym;

endmodule

// File: tb/tb_ccsds_turbo_enc_sink.sv
// tb/tb_ccsds_turbo_enc_sink.sv - self-checking bench for ccsds_turbo_enc_sink
module tb_ccsds_turbo_enc_sink;
  import ccsds_turbo_enc_sink_pkg::*;

  logic       iclk    = 1'b0;
  logic       ireset  = 1'b1;
  logic       iclkena = 1'b1;
  logic [1:0] icode   = '0;
  logic [7:0] ilast   = '0;
  logic       obusy;

  ccsds_turbo_enc_sink_if #(.pADDR_W(8)) bus ();

  ccsds_turbo_enc_sink #(.pADDR_W(8)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .icode   (icode),
    .ilast   (ilast),
    .obusy   (obusy),
    .bus     (bus)
  );

  always #5 iclk = ~iclk;

  // codeword buffer model, registered read
  logic       mem_s  [256];
  logic [2:0] mem_a0 [256];
  logic [2:0] mem_a1 [256];
  logic       rd_s  = 1'b0;
  logic [2:0] rd_a0 = '0;
  logic [2:0] rd_a1 = '0;
  assign bus.irs  = rd_s;
  assign bus.ira0 = rd_a0;
  assign bus.ira1 = rd_a1;
  always @(posedge iclk)
    if (iclkena && bus.ordval) begin
      rd_s  <= mem_s[bus.oraddr];
      rd_a0 <= mem_a0[bus.oraddr];
      rd_a1 <= mem_a1[bus.oraddr];
    end

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bits_per_word(input int code);
    return (code == 0) ? 2 : (code == 1) ? 3 : (code == 2) ? 4 : 6;
  endfunction

  // reference: list the punctured bits word by word straight from the rate rules
  task automatic model_block(input int code, input int last);
    for (int w = 0; w <= last; w++) begin
      bit s;
      bit [2:0] a0, a1;
      s = mem_s[w]; a0 = mem_a0[w]; a1 = mem_a1[w];
      exp_q.push_back(s);
      if (code == 0) exp_q.push_back((w % 2 == 0) ? a0[0] : a1[0]);
      else if (code == 1) begin exp_q.push_back(a0[0]); exp_q.push_back(a1[0]); end
      else if (code == 2) begin exp_q.push_back(a0[1]); exp_q.push_back(a0[2]); exp_q.push_back(a1[0]); end
      else begin
        exp_q.push_back(a0[0]); exp_q.push_back(a0[1]); exp_q.push_back(a0[2]);
        exp_q.push_back(a1[0]); exp_q.push_back(a1[2]);
      end
    end
  endtask

  task automatic fill_random(input int last);
    for (int w = 0; w <= last; w++) begin
      mem_s[w]  = 1'($urandom_range(1));
      mem_a0[w] = 3'($urandom_range(7));
      mem_a1[w] = 3'($urandom_range(7));
    end
  endtask

  // mode: 0 always ready, 1 toggle, 2 low 10 cycles after first bit, 3 random
  task automatic run_stream(input string tag, input int code, input int last,
                            input int nblk, input int mode);
    int blen, got, sops, eops, rempties, rds, gaps, first_sop, eop_idx, sop2_idx, low_left;
    bit prev_hold, in_blk, done;
    logic [2:0] prev_out;
    blen = bits_per_word(code) * (last + 1);
    got = 0; sops = 0; eops = 0; rempties = 0; rds = 0; gaps = 0; low_left = 0;
    first_sop = -1; eop_idx = -1; sop2_idx = -1;
    prev_hold = 0; in_blk = 0; done = 0; prev_out = '0;
    icode = 2'(code); ilast = 8'(last); bus.ifull = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge iclk);
      if (bus.orempty) rempties++;
      if (bus.ordval)  rds++;
      if (i == 0) chk({tag, " start"}, {obusy, bus.ordval, bus.oraddr}, {1'b1, 1'b1, 8'd0});
      if (prev_hold)
        chk({tag, " hold"}, {bus.oval, bus.osop, bus.oeop, bus.odat}, {1'b1, prev_out});
      if (mode == 0 && in_blk && !bus.oval) gaps++;
      if (bus.oval && !prev_hold && bus.osop) begin
        sops++;
        in_blk = 1;
        if (sops == 1) first_sop = i;
        if (sops == 2) sop2_idx = i;
        if (sops == nblk) bus.ifull = 1'b0;
      end
      case (mode)
        0:       bus.iready = 1'b1;
        1:       bus.iready = (i % 2 == 0);
        2:       bus.iready = (low_left == 0);
        default: bus.iready = ($urandom_range(3) != 0);
      endcase
      if (bus.oval && bus.iready) begin
        if (got < exp_q.size())
          chk({tag, " bit"}, {bus.odat, bus.osop, bus.oeop},
              {exp_q[got], (got % blen) == 0, (got % blen) == blen - 1});
        else
          chk({tag, " extra bit"}, 1, 0);
        got++;
        if (mode == 2 && got == 1) low_left = 10;
        if (bus.oeop) begin
          eops++;
          in_blk = 0;
          if (eops == 1) eop_idx = i;
          if (eops == nblk) done = 1;
        end
      end else if (low_left > 0) begin
        low_left--;
      end
      prev_hold = bus.oval && !bus.iready;
      prev_out  = {bus.osop, bus.oeop, bus.odat};
    end
    repeat (3) begin
      @(negedge iclk);
      if (bus.orempty) rempties++;
      if (bus.ordval)  rds++;
    end
    bus.ifull = 1'b0;
    chk({tag, " finished"}, done, 1);
    chk({tag, " bit count"}, got, nblk * blen);
    chk({tag, " orempty count"}, rempties, nblk);
    chk({tag, " ordval count"}, rds, nblk * (last + 1));
    chk({tag, " sop latency"}, first_sop, 2);
    chk({tag, " idle after"}, {obusy, bus.oval}, 0);
    if (mode == 0) chk({tag, " gaps"}, gaps, 0);
    if (nblk == 2) chk({tag, " b2b sop gap"}, sop2_idx - eop_idx, 4);
  endtask

  typedef struct {
    string      name;
    int         code;
    int         last;
    int         mode;
    logic [3:0]  s;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [23:0] exp;
    int         nexp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    // word k of s at bit k, of a0/a1 at [3k+2:3k]; exp is written first-bit-leftmost
    vecs[0] = '{"r13", 1, 3, 0, 4'b0101, {3'b000, 3'b001, 3'b001, 3'b000},
                {3'b001, 3'b000, 3'b001, 3'b001}, 24'b101011110001, 12};
    vecs[1] = '{"r12", 0, 3, 0, 4'b0000, {3'b001, 3'b001, 3'b001, 3'b001},
                12'd0, 24'b01000100, 8};
    vecs[2] = '{"r16", 3, 1, 1, 4'b0001, {3'b000, 3'b000, 3'b011, 3'b110},
                {3'b000, 3'b000, 3'b100, 3'b001}, 24'b101110011001, 12};
    vecs[3] = '{"r14", 2, 3, 2, 4'b0101, {3'b000, 3'b110, 3'b100, 3'b010},
                {3'b001, 3'b000, 3'b001, 3'b000}, 24'b1100001111100001, 16};

    bus.ifull  = 1'b0;
    bus.iready = 1'b0;
    repeat (2) @(negedge iclk);
    chk("reset outputs", {bus.oval, bus.osop, bus.oeop, bus.odat, bus.orempty,
                          bus.ordval, obusy, bus.oraddr}, 0);
    ireset = 1'b0;
    repeat (2) @(negedge iclk);

    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < 4; w++) begin
        mem_s[w]  = vecs[v].s[w];
        mem_a0[w] = vecs[v].a0[3*w +: 3];
        mem_a1[w] = vecs[v].a1[3*w +: 3];
      end
      exp_q.delete();
      for (int k = 0; k < vecs[v].nexp; k++) exp_q.push_back(vecs[v].exp[vecs[v].nexp - 1 - k]);
      run_stream(vecs[v].name, vecs[v].code, vecs[v].last, 1, vecs[v].mode);
    end

    for (int r = 0; r < 10; r++) begin
      int code, last, mode;
      code = int'($urandom_range(3));
      last = (r == 0) ? 0 : int'($urandom_range(1, 14));
      mode = int'($urandom_range(3));
      fill_random(last);
      exp_q.delete();
      model_block(code, last);
      run_stream($sformatf("rnd%0d", r), code, last, 1, mode);
    end

    fill_random(2);
    exp_q.delete();
    model_block(0, 2);
    model_block(0, 2);
    run_stream("b2b", 0, 2, 2, 0);

    begin
      int rempties;
      rempties = 0;
      fill_random(7);
      icode = cCODE_1by4; ilast = 8'd7; bus.ifull = 1'b1; bus.iready = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge iclk);
        if (bus.orempty) rempties++;
        if (i == 1) bus.ifull = 1'b0;
      end
      chk("mid-run active", {obusy, bus.oval}, 2'b11);
      #2 ireset = 1'b1;
      #1 chk("async reset outputs", {bus.oval, bus.osop, bus.oeop, bus.odat, bus.orempty,
                                     bus.ordval, obusy, bus.oraddr}, 0);
      chk("no orempty on abort", rempties, 0);
      @(negedge iclk);
      ireset = 1'b0;
      repeat (3) @(negedge iclk);
      chk("idle after reset", {obusy, bus.oval, bus.ordval}, 0);
    end

    fill_random(5);
    exp_q.delete();
    model_block(1, 5);
    run_stream("after reset", 1, 5, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_enc_sink.md
# ccsds_turbo_enc_sink

Output interface of the CCSDS turbo encoder, the transmit-side counterpart of the decoder input stage. It reads one encoded trellis-step word per address from the encoder codeword buffer: systematic bit plus both constituent-encoder parity sets. It serialises the bits in CCSDS puncture order for the selected code rate and emits one bit per cycle under a valid/ready handshake, with start-of-packet and end-of-packet framing. Reads are prefetched so the output stream has no bubbles while the downstream side is ready.

## Interface
- pADDR_W, 8, codeword buffer address width; word count per block ≤ 2^pADDR_W
- iclk  in  1  clock
- ireset  in  1  reset, asynchronous, active-high
- iclkena  in  1  clock enable; all state frozen when low
- icode  in  2  code rate (cCODE_1by2/1by3/1by4/1by6), sampled at block start
- ilast  in  pADDR_W  index of the last word (data plus 4 tail steps, minus 1), sampled at block start
- ifull  in  1  codeword buffer holds a complete block
- orempty  out  1  one-cycle pulse: last word of the block has been read, buffer may be released
- oraddr  out  pADDR_W  buffer read address; read latency fixed at 1 cycle
- ordval  out  1  read strobe
- irs  in  1  systematic bit from the buffer
- ira0  in  3  encoder-0 parity bits [0..2]
- ira1  in  3  encoder-1 parity bits [0..2]; bit 1 unused
- oval  out  1  output bit valid
- osop  out  1  first bit of the codeword
- oeop  out  1  last bit of the codeword
- odat  out  1  output bit
- iready  in  1  downstream accepts the current bit when oval & iready
- obusy  out  1  block in progress

## Operation
- The bit order per word is fixed by icode:
  - 1/2: s, then p; p = ira0[0] on even words, ira1[0] on odd words. Word 0 is even.
  - 1/3: s, ira0[0], ira1[0].
  - 1/4: s, ira0[1], ira0[2], ira1[0].
  - 1/6: s, ira0[0], ira0[1], ira0[2], ira1[0], ira1[2].
- The bits per word are N = 2/3/4/6. A symbol counter runs 0..N-1, and the word counter runs 0..ilast.
- FSM states:
  - IDLE → FETCH when ifull = 1. The block latches code and last, and issues the read for word 0.
  - FETCH → RUN when the word 0 data returns. The block loads the shift register and raises oval and osop.
  - RUN → IDLE when the bit with oeop set is accepted.
- Prefetch: each load of word k into the shift register issues the read for word k+1, provided k < last.
- Returned data is handled as follows:
  - It loads the shift register directly if the current last symbol is accepted in that cycle.
  - Otherwise it is parked in a one-word skid register, tagged valid.
  - The next last-symbol acceptance loads from the skid register.
- orempty pulses in the cycle after the data for word `last` is captured.
- osop is set on symbol 0 of word 0 only. oeop is set on symbol N-1 of word `last` only.
- An ifull change during RUN is ignored. The next block may start only from IDLE.
- Reset mid-block: all state is cleared, the output stops immediately, and no orempty is issued.

## Timing
- Reset values: oval=0, osop=0, oeop=0, odat=0, orempty=0, ordval=0, obusy=0, oraddr=0. Internal counters, skid-valid and FSM are reset to IDLE.
- Latency: ifull is sampled high in IDLE at cycle t. ordval/oraddr=0 are driven in t+1, data returns in t+2, and oval/osop rise in t+3.
- Throughput: 1 bit per accepted cycle, with no bubbles at word boundaries for any rate, including N=2.
- Handshake: odat, osop and oeop are stable while oval & !iready. A bit advances only on oval & iready.
- Block length: N·(last+1) bits, with exactly one osop and one oeop.
- obusy is high from t+1 until the eop bit is accepted, inclusive.
- Back-to-back: the eop bit is accepted at cycle e with ifull high. The next block's osop appears at e+4 at the earliest.

## Structure
- The shared package holds cCODE_* constants and a get_code_nbits(code) function returning 2/3/4/6. The decoder source uses the same constants.
- The single module contains the FSM, counters, skid register and output mux.
- An optional sub-module, ccsds_turbo_enc_sink_skid, holds the one-word skid register and valid flag.

## Test plan
- Rate 1/3, last=3, iready=1, words s/a0/a1 = {1,0,1},{0,1,1},{1,1,0},{0,0,1}:
  - Expected output 101 011 110 001.
  - osop at t+3, oeop on bit 12, orempty once.
- Rate 1/2, last=3, ira0[0]=1, ira1[0]=0, irs=0 for all words:
  - Expected output 01 00 01 00.
  - There must be no gaps between words.
- Rate 1/6, last=1, iready toggling 1-0-1-0:
  - All 12 bits are in order, with held values stable while stalled.
  - ordval is asserted exactly twice.
- Rate 1/4, iready low for 10 cycles after the first bit:
  - The skid register fills, with no lost or duplicated word.
  - The stream resumes correctly.
- ireset asserted mid-RUN:
  - All outputs go to 0 asynchronously and the FSM returns to IDLE.
  - The next block after ifull starts cleanly with osop.
- Back-to-back blocks with ifull held high:
  - The second osop appears 4 cycles after the first eop is accepted.
  - Exactly two orempty pulses.
